// File: rtl/expansion_slot_gen2_pkg.sv
// Shared types for the MSX secondary-slot expander.
// Slot numbers, settle FSM states and register defaults.
package msx_slot_pkg;

    typedef logic [1:0] sec_slot_t;

    typedef enum logic {
        SETTLE_IDLE,
        SETTLE_BUSY
    } settle_state_t;

    localparam logic [15:0] DEF_SLTEXP_ADDR = 16'hFFFF;
    localparam logic [7:0]  DEF_SLTEXP_INIT = 8'h00;

    // Two-bit secondary slot field for a 16 KiB page.
    function automatic sec_slot_t page_slot(
        input logic [7:0] sltexp,
        input logic [1:0] page
    );
        logic [7:0] sh;
        sh = sltexp >> {page, 1'b0};
        return sh[1:0];
    endfunction

endpackage

// File: rtl/bus_if.sv
// MSX cartridge slot bus, seen from the cartridge side (CARTRIDGE)
// or from the host side (MSX).
interface BUS_IF;
    logic        RESET_n;
    logic        CLK;
    logic        SLTSL_n;
    logic        MERQ_n;
    logic        IORQ_n;
    logic        RD_n;
    logic        WR_n;
    logic [15:0] ADDR;
    logic [7:0]  DIN;
    logic [7:0]  DOUT;
    logic        BUSDIR_n;
    logic        WAIT_n;
    logic        INT_n;

    modport CARTRIDGE (
        input  RESET_n, CLK, SLTSL_n, MERQ_n, IORQ_n, RD_n, WR_n, ADDR, DIN,
        output DOUT, BUSDIR_n, WAIT_n, INT_n
    );

    modport MSX (
        output RESET_n, CLK, SLTSL_n, MERQ_n, IORQ_n, RD_n, WR_n, ADDR, DIN,
        input  DOUT, BUSDIR_n, WAIT_n, INT_n
    );
endinterface

// File: rtl/expansion_slot_gen2_settle_timer.sv
// Wait-state sequencer: holds wait_n low for SETTLE_CYCLES clocks
// after each slot-select write.
module slot_settle_timer import msx_slot_pkg::*; #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic RESET_n,
    input  logic CLK,
    input  logic start,
    input  logic abort,
    output logic wait_n
);

    localparam logic [3:0] LOAD   = 4'(SETTLE_CYCLES);
    localparam logic       ENABLE = (SETTLE_CYCLES > 0);

    settle_state_t state;
    logic [3:0]    cnt;

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state  <= SETTLE_IDLE;
            cnt    <= '0;
            wait_n <= 1'b1;
        end else if (abort) begin
            state  <= SETTLE_IDLE;
            cnt    <= '0;
            wait_n <= 1'b1;
        end else if (start && ENABLE) begin
            // a write during SETTLE restarts the full settle period
            state  <= SETTLE_BUSY;
            cnt    <= LOAD;
            wait_n <= 1'b0;
        end else begin
            unique case (state)
                SETTLE_IDLE: begin
                    cnt    <= '0;
                    wait_n <= 1'b1;
                end
                SETTLE_BUSY: begin
                    if (cnt <= 4'd1) begin
                        state  <= SETTLE_IDLE;
                        cnt    <= '0;
                        wait_n <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/expansion_slot_gen2.sv
// Secondary-slot expander: one primary cartridge slot fanned out to
// up to four secondary buses via the slot-select register.
module expansion_slot_gen2 import msx_slot_pkg::*; #(
    parameter int          COUNT         = 4,
    parameter logic [15:0] SLTEXP_ADDR   = DEF_SLTEXP_ADDR,
    parameter logic [7:0]  SLTEXP_INIT   = DEF_SLTEXP_INIT,
    parameter int          SETTLE_CYCLES = 2,
    parameter logic        READ_INVERT   = 1'b1
) (
    input  logic       RESET_n,
    input  logic       CLK,
    BUS_IF.CARTRIDGE   Primary,
    BUS_IF.MSX         Secondary [0:COUNT-1],
    input  logic       WAIT_n,
    output logic [7:0] SLTEXP,
    output logic       CONFLICT,
    input  logic       CONFLICT_CLR
);

    logic       wr_n;
    logic       prev_wr_n;
    logic       det_wr;
    logic       reg_hit;
    logic       reg_wr;
    logic [7:0] sltexp;
    logic [7:0] my_dout;
    logic       my_busdir_n;
    logic       wait_q;
    logic       conflict_q;
    sec_slot_t  field;

    logic [COUNT-1:0] sec_wait_n;
    logic [COUNT-1:0] sec_int_n;
    logic [COUNT-1:0] sec_busdir_n;
    logic [7:0]       sec_dout [COUNT];
    logic [7:0]       sec_dout_or;
    logic [COUNT:0]   rd_active;
    logic             multi_drive;

    assign wr_n    = Primary.SLTSL_n | Primary.MERQ_n | Primary.WR_n;
    assign det_wr  = prev_wr_n & ~wr_n;
    assign reg_hit = ~Primary.SLTSL_n & ~Primary.MERQ_n
                   & (Primary.ADDR == SLTEXP_ADDR);
    assign reg_wr  = det_wr & reg_hit;
    assign field   = page_slot(sltexp, Primary.ADDR[15:14]);

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            prev_wr_n   <= 1'b1;
            sltexp      <= SLTEXP_INIT;
            my_busdir_n <= 1'b1;
            my_dout     <= '0;
        end else if (!Primary.RESET_n) begin
            prev_wr_n   <= 1'b1;
            sltexp      <= SLTEXP_INIT;
            my_busdir_n <= 1'b1;
            my_dout     <= '0;
        end else begin
            prev_wr_n <= wr_n;
            if (reg_wr) begin
                sltexp <= Primary.DIN;
            end
            if (reg_hit && !Primary.RD_n) begin
                my_busdir_n <= 1'b0;
                my_dout     <= READ_INVERT ? ~sltexp : sltexp;
            end else begin
                my_busdir_n <= 1'b1;
                my_dout     <= '0;
            end
        end
    end

    slot_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle (
        .RESET_n (RESET_n),
        .CLK     (CLK),
        .start   (reg_wr),
        .abort   (~Primary.RESET_n),
        .wait_n  (wait_q)
    );

    for (genvar n = 0; n < COUNT; n++) begin : g_sec
        assign Secondary[n].RESET_n = Primary.RESET_n;
        assign Secondary[n].CLK     = Primary.CLK;
        assign Secondary[n].MERQ_n  = Primary.MERQ_n;
        assign Secondary[n].IORQ_n  = Primary.IORQ_n;
        assign Secondary[n].RD_n    = Primary.RD_n;
        assign Secondary[n].WR_n    = Primary.WR_n;
        assign Secondary[n].ADDR    = Primary.ADDR;
        assign Secondary[n].DIN     = Primary.DIN;
        // the register itself never reaches a secondary
        assign Secondary[n].SLTSL_n = Primary.SLTSL_n
                                    | (field != sec_slot_t'(n))
                                    | reg_hit;

        assign sec_wait_n[n]   = Secondary[n].WAIT_n;
        assign sec_int_n[n]    = Secondary[n].INT_n;
        assign sec_busdir_n[n] = Secondary[n].BUSDIR_n;
        assign sec_dout[n]     = Secondary[n].DOUT;
    end

    always_comb begin
        sec_dout_or = '0;
        for (int i = 0; i < COUNT; i++) begin
            sec_dout_or = sec_dout_or | sec_dout[i];
        end
    end

    assign Primary.WAIT_n   = wait_q & WAIT_n & (&sec_wait_n);
    assign Primary.INT_n    = &sec_int_n;
    assign Primary.BUSDIR_n = my_busdir_n & (&sec_busdir_n);
    assign Primary.DOUT     = !my_busdir_n ? my_dout : sec_dout_or;

    // two or more drivers: x & (x - 1) is non-zero
    assign rd_active   = {~sec_busdir_n, ~my_busdir_n};
    assign multi_drive = |(rd_active & (rd_active - {{COUNT{1'b0}}, 1'b1}));

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            conflict_q <= 1'b0;
        end else if (multi_drive) begin
            conflict_q <= 1'b1;
        end else if (CONFLICT_CLR) begin
            conflict_q <= 1'b0;
        end
    end

    assign SLTEXP   = sltexp;
    assign CONFLICT = conflict_q;

endmodule

// File: tb/tb_expansion_slot_gen2.sv
// Directed bench for expansion_slot_gen2: a 4-slot instance with
// 3-cycle settle and a 2-slot instance with settle disabled.
module tb_expansion_slot_gen2;

    logic CLK = 1'b0;
    logic RESET_n = 1'b1;

    logic        p_rst_n;
    logic        sltsl_n, merq_n, iorq_n, rd_n, wr_n;
    logic [15:0] addr;
    logic [7:0]  din;
    logic        ext_wait_n;
    logic        conflict_clr;

    logic [7:0]  sa_dout [4];
    logic [3:0]  sa_busdir_n;
    logic [3:0]  sa_wait_n;
    logic [3:0]  sa_int_n;
    logic [3:0]  sa_sltsl;
    logic [3:0]  sa_rst;
    logic [1:0]  sb_sltsl;

    logic [7:0]  a_sltexp, b_sltexp;
    logic        a_conflict, b_conflict;

    int total = 0;
    int bad = 0;

    always #5 CLK = ~CLK;

    BUS_IF pa ();
    BUS_IF pb ();
    BUS_IF sa [0:3] ();
    BUS_IF sb [0:1] ();

    assign pa.RESET_n = p_rst_n;
    assign pa.CLK     = CLK;
    assign pa.SLTSL_n = sltsl_n;
    assign pa.MERQ_n  = merq_n;
    assign pa.IORQ_n  = iorq_n;
    assign pa.RD_n    = rd_n;
    assign pa.WR_n    = wr_n;
    assign pa.ADDR    = addr;
    assign pa.DIN     = din;

    assign pb.RESET_n = p_rst_n;
    assign pb.CLK     = CLK;
    assign pb.SLTSL_n = sltsl_n;
    assign pb.MERQ_n  = merq_n;
    assign pb.IORQ_n  = iorq_n;
    assign pb.RD_n    = rd_n;
    assign pb.WR_n    = wr_n;
    assign pb.ADDR    = addr;
    assign pb.DIN     = din;

    for (genvar i = 0; i < 4; i++) begin : g_sa
        assign sa[i].DOUT     = sa_dout[i];
        assign sa[i].BUSDIR_n = sa_busdir_n[i];
        assign sa[i].WAIT_n   = sa_wait_n[i];
        assign sa[i].INT_n    = sa_int_n[i];
        assign sa_sltsl[i]    = sa[i].SLTSL_n;
        assign sa_rst[i]      = sa[i].RESET_n;
    end

    for (genvar i = 0; i < 2; i++) begin : g_sb
        assign sb[i].DOUT     = 8'h00;
        assign sb[i].BUSDIR_n = 1'b1;
        assign sb[i].WAIT_n   = 1'b1;
        assign sb[i].INT_n    = 1'b1;
        assign sb_sltsl[i]    = sb[i].SLTSL_n;
    end

    expansion_slot_gen2 #(
        .COUNT         (4),
        .SLTEXP_ADDR   (16'hFFFF),
        .SLTEXP_INIT   (8'hE4),
        .SETTLE_CYCLES (3),
        .READ_INVERT   (1'b1)
    ) u_a (
        .RESET_n      (RESET_n),
        .CLK          (CLK),
        .Primary      (pa),
        .Secondary    (sa),
        .WAIT_n       (ext_wait_n),
        .SLTEXP       (a_sltexp),
        .CONFLICT     (a_conflict),
        .CONFLICT_CLR (conflict_clr)
    );

    expansion_slot_gen2 #(
        .COUNT         (2),
        .SLTEXP_ADDR   (16'hFFFF),
        .SLTEXP_INIT   (8'hFF),
        .SETTLE_CYCLES (0),
        .READ_INVERT   (1'b1)
    ) u_b (
        .RESET_n      (RESET_n),
        .CLK          (CLK),
        .Primary      (pb),
        .Secondary    (sb),
        .WAIT_n       (ext_wait_n),
        .SLTEXP       (b_sltexp),
        .CONFLICT     (b_conflict),
        .CONFLICT_CLR (conflict_clr)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic bus_idle();
        sltsl_n = 1'b1;
        merq_n  = 1'b1;
        iorq_n  = 1'b1;
        rd_n    = 1'b1;
        wr_n    = 1'b1;
        addr    = 16'h0000;
        din     = 8'h00;
    endtask

    task automatic drive_write(input logic [15:0] a, input logic [7:0] d);
        sltsl_n = 1'b0;
        merq_n  = 1'b0;
        wr_n    = 1'b0;
        rd_n    = 1'b1;
        addr    = a;
        din     = d;
    endtask

    task automatic drive_read(input logic [15:0] a);
        sltsl_n = 1'b0;
        merq_n  = 1'b0;
        wr_n    = 1'b1;
        rd_n    = 1'b0;
        addr    = a;
    endtask

    task automatic test_reset();
        p_rst_n      = 1'b1;
        ext_wait_n   = 1'b1;
        conflict_clr = 1'b0;
        sa_busdir_n  = 4'hF;
        sa_wait_n    = 4'hF;
        sa_int_n     = 4'hF;
        for (int i = 0; i < 4; i++) sa_dout[i] = 8'h00;
        bus_idle();
        #1 RESET_n = 1'b0;
        repeat (2) tick();
        @(negedge CLK);
        total++;
        if (a_sltexp !== 8'hE4) begin
            bad++;
            $display("FAIL reset_sltexp: got %h want e4", a_sltexp);
        end
        total++;
        if (pa.BUSDIR_n !== 1'b1 || a_conflict !== 1'b0) begin
            bad++;
            $display("FAIL reset_outs: busdir %b conflict %b want 1 0",
                     pa.BUSDIR_n, a_conflict);
        end
        total++;
        if (pa.WAIT_n !== 1'b1 || b_sltexp !== 8'hFF) begin
            bad++;
            $display("FAIL reset_wait_b: wait %b b_sltexp %h want 1 ff",
                     pa.WAIT_n, b_sltexp);
        end
        tick();
        RESET_n = 1'b1;
        tick();
    endtask

    task automatic test_readback();
        drive_read(16'hFFFF);
        @(negedge CLK);
        total++;
        if (pa.BUSDIR_n !== 1'b1 || sa_sltsl !== 4'hF) begin
            bad++;
            $display("FAIL rd_latency: busdir %b sltsl %b want 1 1111",
                     pa.BUSDIR_n, sa_sltsl);
        end
        tick();
        @(negedge CLK);
        total++;
        if (pa.BUSDIR_n !== 1'b0 || pa.DOUT !== 8'h1B) begin
            bad++;
            $display("FAIL rd_data: busdir %b dout %h want 0 1b",
                     pa.BUSDIR_n, pa.DOUT);
        end
        tick();
        bus_idle();
        @(negedge CLK);
        total++;
        if (pa.BUSDIR_n !== 1'b0) begin
            bad++;
            $display("FAIL rd_hold: busdir %b want 0", pa.BUSDIR_n);
        end
        tick();
        @(negedge CLK);
        total++;
        if (pa.BUSDIR_n !== 1'b1 || pa.DOUT !== 8'h00) begin
            bad++;
            $display("FAIL rd_release: busdir %b dout %h want 1 00",
                     pa.BUSDIR_n, pa.DOUT);
        end
        tick();
    endtask

    task automatic test_write_route();
        logic [15:0] pg_addr [4];
        logic [3:0]  pg_sel [4];
        pg_addr = '{16'h4000, 16'h8000, 16'hC000, 16'h0000};
        pg_sel  = '{4'b1011, 4'b0111, 4'b1110, 4'b1101};
        drive_write(16'hFFFF, 8'h39);
        tick();
        bus_idle();
        @(negedge CLK);
        total++;
        if (a_sltexp !== 8'h39) begin
            bad++;
            $display("FAIL wr_sltexp: got %h want 39", a_sltexp);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            drive_read(pg_addr[i]);
            @(negedge CLK);
            total++;
            if (sa_sltsl !== pg_sel[i]) begin
                bad++;
                $display("FAIL route_%h: sltsl %b want %b",
                         pg_addr[i], sa_sltsl, pg_sel[i]);
            end
        end
        tick();
        bus_idle();
        merq_n = 1'b0;
        rd_n   = 1'b0;
        addr   = 16'h4000;
        @(negedge CLK);
        total++;
        if (sa_sltsl !== 4'hF) begin
            bad++;
            $display("FAIL route_unselected: sltsl %b want 1111", sa_sltsl);
        end
        tick();
        bus_idle();
        repeat (4) tick();
    endtask

    task automatic test_settle();
        logic [4:0] s1;
        logic [6:0] s2;
        drive_write(16'hFFFF, 8'h39);
        @(negedge CLK);
        total++;
        if (pa.WAIT_n !== 1'b1) begin
            bad++;
            $display("FAIL settle_pre: wait %b want 1", pa.WAIT_n);
        end
        tick();
        bus_idle();
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            s1[i] = pa.WAIT_n;
            tick();
        end
        total++;
        if (s1 !== 5'b11000) begin
            bad++;
            $display("FAIL settle_single: wait trace %b want 11000", s1);
        end
        drive_write(16'hFFFF, 8'h39);
        tick();
        bus_idle();
        for (int i = 0; i < 7; i++) begin
            @(negedge CLK);
            s2[i] = pa.WAIT_n;
            tick();
            if (i == 0) drive_write(16'hFFFF, 8'h39);
            if (i == 1) bus_idle();
        end
        total++;
        if (s2 !== 7'b1100000) begin
            bad++;
            $display("FAIL settle_reload: wait trace %b want 1100000", s2);
        end
    endtask

    task automatic test_return();
        ext_wait_n = 1'b0;
        @(negedge CLK);
        total++;
        if (pa.WAIT_n !== 1'b0) begin
            bad++;
            $display("FAIL ext_wait: wait %b want 0", pa.WAIT_n);
        end
        ext_wait_n = 1'b1;
        sa_wait_n  = 4'b0111;
        #1;
        total++;
        if (pa.WAIT_n !== 1'b0) begin
            bad++;
            $display("FAIL sec_wait: wait %b want 0", pa.WAIT_n);
        end
        sa_wait_n = 4'hF;
        sa_int_n  = 4'b1011;
        #1;
        total++;
        if (pa.INT_n !== 1'b0 || pa.WAIT_n !== 1'b1) begin
            bad++;
            $display("FAIL int_and: int %b wait %b want 0 1",
                     pa.INT_n, pa.WAIT_n);
        end
        sa_int_n = 4'hF;
        tick();
    endtask

    task automatic test_conflict();
        sa_busdir_n = 4'b1001;
        sa_dout[1]  = 8'h0F;
        sa_dout[2]  = 8'hF0;
        @(negedge CLK);
        total++;
        if (a_conflict !== 1'b0 || pa.BUSDIR_n !== 1'b0
            || pa.DOUT !== 8'hFF) begin
            bad++;
            $display("FAIL cf_cycle: conflict %b busdir %b dout %h want 0 0 ff",
                     a_conflict, pa.BUSDIR_n, pa.DOUT);
        end
        tick();
        sa_busdir_n = 4'hF;
        sa_dout[1]  = 8'h00;
        sa_dout[2]  = 8'h00;
        @(negedge CLK);
        total++;
        if (a_conflict !== 1'b1) begin
            bad++;
            $display("FAIL cf_set: conflict %b want 1", a_conflict);
        end
        tick();
        @(negedge CLK);
        total++;
        if (a_conflict !== 1'b1) begin
            bad++;
            $display("FAIL cf_sticky: conflict %b want 1", a_conflict);
        end
        tick();
        conflict_clr = 1'b1;
        sa_busdir_n  = 4'b1001;
        tick();
        sa_busdir_n  = 4'hF;
        @(negedge CLK);
        total++;
        if (a_conflict !== 1'b1) begin
            bad++;
            $display("FAIL cf_set_wins: conflict %b want 1", a_conflict);
        end
        tick();
        conflict_clr = 1'b0;
        @(negedge CLK);
        total++;
        if (a_conflict !== 1'b0) begin
            bad++;
            $display("FAIL cf_clear: conflict %b want 0", a_conflict);
        end
        tick();
        drive_read(16'hFFFF);
        sa_busdir_n = 4'b0111;
        tick();
        bus_idle();
        tick();
        sa_busdir_n = 4'hF;
        @(negedge CLK);
        total++;
        if (a_conflict !== 1'b1) begin
            bad++;
            $display("FAIL cf_reg_vs_sec: conflict %b want 1", a_conflict);
        end
        tick();
        conflict_clr = 1'b1;
        tick();
        conflict_clr = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_primary_reset();
        sa_busdir_n = 4'b0110;
        drive_write(16'hFFFF, 8'hFF);
        tick();
        sa_busdir_n = 4'hF;
        bus_idle();
        p_rst_n = 1'b0;
        @(negedge CLK);
        total++;
        if (pa.WAIT_n !== 1'b0 || a_sltexp !== 8'hFF) begin
            bad++;
            $display("FAIL prst_before: wait %b sltexp %h want 0 ff",
                     pa.WAIT_n, a_sltexp);
        end
        total++;
        if (sa_rst !== 4'h0 || pb.WAIT_n !== 1'b1) begin
            bad++;
            $display("FAIL prst_pass: sec_rst %b b_wait %b want 0000 1",
                     sa_rst, pb.WAIT_n);
        end
        tick();
        @(negedge CLK);
        total++;
        if (pa.WAIT_n !== 1'b1 || a_sltexp !== 8'hE4
            || a_conflict !== 1'b1) begin
            bad++;
            $display("FAIL prst_after: wait %b sltexp %h conflict %b want 1 e4 1",
                     pa.WAIT_n, a_sltexp, a_conflict);
        end
        tick();
        p_rst_n      = 1'b1;
        conflict_clr = 1'b1;
        tick();
        conflict_clr = 1'b0;
        tick();
    endtask

    task automatic test_count2();
        logic [15:0] pg_addr [4];
        pg_addr = '{16'h0000, 16'h4000, 16'h8000, 16'hC000};
        for (int i = 0; i < 4; i++) begin
            drive_read(pg_addr[i]);
            @(negedge CLK);
            total++;
            if (sb_sltsl !== 2'b11 || b_sltexp !== 8'hFF) begin
                bad++;
                $display("FAIL c2_sel_%h: sltsl %b sltexp %h want 11 ff",
                         pg_addr[i], sb_sltsl, b_sltexp);
            end
            tick();
            @(negedge CLK);
            total++;
            if (pb.BUSDIR_n !== 1'b1 || pb.DOUT !== 8'h00) begin
                bad++;
                $display("FAIL c2_ret_%h: busdir %b dout %h want 1 00",
                         pg_addr[i], pb.BUSDIR_n, pb.DOUT);
            end
            tick();
        end
        bus_idle();
        tick();
    endtask

    task automatic test_back_to_back();
        drive_write(16'hFFFF, 8'h12);
        tick();
        din = 8'h34;
        tick();
        bus_idle();
        @(negedge CLK);
        total++;
        if (a_sltexp !== 8'h12) begin
            bad++;
            $display("FAIL b2b_single_load: sltexp %h want 12", a_sltexp);
        end
        repeat (5) tick();
    endtask

    initial begin
        test_reset();
        test_readback();
        test_write_route();
        test_settle();
        test_return();
        test_conflict();
        test_primary_reset();
        test_count2();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not end, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/expansion_slot_gen2.md
# expansion_slot_gen2

Second-generation MSX secondary-slot expander: sits between one primary cartridge slot (`BUS_IF.CARTRIDGE`) and up to four secondary slot buses (`BUS_IF.MSX`). It adds four things:
- a configurable register address and power-on value;
- a settle wait-state sequencer after every slot-select write;
- masking of register accesses from the secondaries;
- sticky detection of read-bus contention.

## Interface
Parameters:
- `COUNT`, 4, number of secondary buses, legal 1..4.
- `SLTEXP_ADDR`, 16'hFFFF, memory address of the slot-select register.
- `SLTEXP_INIT`, 8'h00, register value after any reset.
- `SETTLE_CYCLES`, 2, `CLK` cycles of forced WAIT after a register write; 0 disables the wait, legal 0..15.
- `READ_INVERT`, 1, 1: readback is `~sltexp`; 0: readback is `sltexp`.

Ports:
- `RESET_n`, in, 1: reset, asynchronous, active-low.
- `CLK`, in, 1: clock.
- `Primary`, `BUS_IF.CARTRIDGE`: upstream slot.
- `Secondary[0:COUNT-1]`, `BUS_IF.MSX`: downstream slots.
- `WAIT_n`, in, 1: external wait, ANDed into `Primary.WAIT_n`.
- `SLTEXP`, out, 8: current register value.
- `CONFLICT`, out, 1: sticky read-contention flag.
- `CONFLICT_CLR`, in, 1: synchronous clear of `CONFLICT`.

## Operation
- Access strobes:
  - `wr_n = SLTSL_n | MERQ_n | WR_n`; write edge `det_wr = prev_wr_n & ~wr_n`; `prev_wr_n` resets to 1.
  - `reg_hit = ~SLTSL_n & ~MERQ_n & (ADDR == SLTEXP_ADDR)`.
- Register write: `det_wr & reg_hit` loads `sltexp <= DIN`.
- Register readback: `reg_hit & ~RD_n` registers `my_dout` (per `READ_INVERT`) and `my_busdir_n = 0`. Otherwise `my_dout = 0` and `my_busdir_n = 1`.
- Routing:
  - Page is `ADDR[15:14]` and selects field `sltexp[2p+1:2p]`.
  - `Secondary[n].SLTSL_n = Primary.SLTSL_n | (field != n) | reg_hit`. The register is never visible downstream.
  - All other strobes, address, data, clocks and `RESET_n` pass through combinationally.
- Settle sequencer:
  - Two-state FSM, IDLE and SETTLE, with a 4-bit down-counter `cnt`.
  - IDLE → SETTLE on a register write when `SETTLE_CYCLES > 0`; loads `cnt = SETTLE_CYCLES`.
  - SETTLE decrements `cnt` each cycle and returns to IDLE when `cnt` reaches 1.
  - A new register write while in SETTLE reloads `cnt`.
- Upstream return:
  - `Primary.WAIT_n = wait_q & WAIT_n & AND(Secondary.WAIT_n)`, where `wait_q` is a registered 0 in SETTLE and 1 in IDLE.
  - `INT_n` = AND of all secondaries.
  - `DOUT`/`BUSDIR_n` = register value and 0 when `my_busdir_n = 0`; otherwise OR of secondary `DOUT` and AND of secondary `BUSDIR_n`.
- Conflict detection:
  - `CONFLICT` sets when two or more of {`~my_busdir_n`, `~Secondary[n].BUSDIR_n`} are active in the same cycle.
  - Cleared by `CONFLICT_CLR`; a set and a clear in the same cycle resolve to set.
  - Unaffected by `Primary.RESET_n`.

## Timing
- Reset, `RESET_n` low, asynchronous:
  - `sltexp = SLTEXP_INIT`, FSM IDLE, `cnt = 0`, `wait_q = 1`, `my_busdir_n = 1`, `my_dout = 0`, `CONFLICT = 0`, `prev_wr_n = 1`.
  - Outputs: `Primary.BUSDIR_n = 1`, `Primary.WAIT_n` follows the inputs.
- `Primary.RESET_n` low, synchronous: same as above except `CONFLICT` is held. A SETTLE in progress is aborted and `wait_q` goes to 1 on the next edge.
- Register write: write-edge sampled at edge N.
  - `sltexp` and `SLTEXP` take the new value after N.
  - `wait_q` is low for exactly `SETTLE_CYCLES` cycles following N.
  - Routing uses the new value from cycle N+1.
- Readback: one-cycle latency from `RD_n` falling to `BUSDIR_n`/`DOUT` valid. Deasserts one cycle after `RD_n` rises.
- `CONFLICT` asserts one cycle after the contention cycle.
- Back-to-back writes with `wr_n` held low produce only one edge and one load.

## Structure
- Shared package `msx_slot_pkg`:
  - `typedef logic [1:0] sec_slot_t`;
  - `typedef enum logic {SETTLE_IDLE, SETTLE_BUSY}`;
  - `localparam` default register address and init value.
- One sub-module, `slot_settle_timer`: holds the FSM, counter and `wait_q`, with inputs `start` and `abort` and output `wait_n`.
- Routing, strobe and return-OR logic sit in a generate loop in the top module.

## Test plan
- Reset with `SLTEXP_INIT = 8'hE4`, then read `FFFF` (`READ_INVERT = 1`) -> `DOUT = 8'h1B`, `BUSDIR_n = 0` one cycle after `RD_n` low, no secondary `SLTSL_n` low.
- Write `8'h39` to `FFFF`, then read `4000h`, `8000h` and `C000h` -> `SLTSL_n` low on Secondary 2, 3 and 0 respectively; `SLTEXP = 8'h39`.
- `SETTLE_CYCLES = 3`, write `FFFF` -> `Primary.WAIT_n` low exactly 3 cycles. A second write in the 2nd cycle -> the low period extends to 3 cycles after the second write.
- Secondaries 1 and 2 both drive `BUSDIR_n = 0` for one cycle -> `CONFLICT = 1` next cycle and holds; `CONFLICT_CLR` together with new contention -> stays 1; `CONFLICT_CLR` alone -> 0.
- Assert `Primary.RESET_n` mid-SETTLE with `sltexp = 8'hFF` -> `WAIT_n` releases next cycle, `sltexp = SLTEXP_INIT`, `CONFLICT` unchanged.
- `COUNT = 2`, `sltexp = 8'hFF` -> accesses to every page select no secondary; `BUSDIR_n = 1`, `DOUT = 0`.
